// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one registered signed multiplier among NUM_REQ requesters.
// Define MULT_SHARE_STATS_EN to add issue/stall counters with a synchronous clear.
module mult_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH_A = 10,
    parameter  int WIDTH_B = 8,
    localparam int WIDTH_C = WIDTH_A + WIDTH_B,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0] req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0] req_b,
    output logic                       mul_valid,
    output logic [WIDTH_A-1:0]         mul_a,
    output logic [WIDTH_B-1:0]         mul_b,
    input  logic [WIDTH_C-1:0]         mul_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH_C-1:0]         rsp_c
`ifdef MULT_SHARE_STATS_EN
    ,
    input  logic                       stat_clear,
    output logic [31:0]                stat_issue_cnt,
    output logic [31:0]                stat_stall_cnt
`endif
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_found;
    logic            can_issue;
    logic            issue;

    assign can_issue = !rsp_valid || rsp_ready;
    assign issue     = can_issue && grant_found;
    assign rsp_c     = mul_c;
    assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Scan requesters starting at rr_ptr, wrapping; the first valid one wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            mul_valid            = 1'b1;
            mul_a                = req_a[grant_idx*WIDTH_A +: WIDTH_A];
            mul_b                = req_b[grant_idx*WIDTH_B +: WIDTH_B];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else if (issue) begin
            rr_ptr    <= next_ptr;
            rsp_id    <= grant_idx;
            rsp_valid <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef MULT_SHARE_STATS_EN
    logic stall;
    assign stall = |req_valid && !can_issue;

    // Clear wins over increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else if (stat_clear) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (issue && (stat_issue_cnt != '1)) begin
                stat_issue_cnt <= stat_issue_cnt + 32'd1;
            end
            if (stall && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural registered multiplier.
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WA      = 10;
    localparam int WB      = 8;
    localparam int WC      = WA + WB;

    typedef struct packed {
        logic [1:0]    id;
        logic [WC-1:0] c;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*WA-1:0] req_a;
    logic [NUM_REQ*WB-1:0] req_b;
    logic                  mul_valid;
    logic [WA-1:0]         mul_a;
    logic [WB-1:0]         mul_b;
    logic [WC-1:0]         mul_c;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WC-1:0]         rsp_c;
`ifdef MULT_SHARE_STATS_EN
    logic                  stat_clear;
    logic [31:0]           stat_issue_cnt;
    logic [31:0]           stat_stall_cnt;
`endif

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c)
`ifdef MULT_SHARE_STATS_EN
        ,
        .stat_clear     (stat_clear),
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External shared multiplier: captures a*b when data_valid, holds otherwise.
    logic signed [WC-1:0] ext_a;
    logic signed [WC-1:0] ext_b;
    logic signed [WC-1:0] prod;
    assign ext_a = {{WB{mul_a[WA-1]}}, mul_a};
    assign ext_b = {{WA{mul_b[WB-1]}}, mul_b};
    assign prod  = ext_a * ext_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_c <= '0;
        end else if (mul_valid) begin
            mul_c <= prod;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ready);
        @(posedge clk);
        #1;
        req_valid = valid;
        rsp_ready = ready;
        #1;
    endtask

    task automatic setOperand(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        req_a[i*WA +: WA] = a;
        req_b[i*WB +: WB] = b;
    endtask

    // Monitor: every accepted response is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                checkOutput("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                checkOutput("rsp_c", 32'(rsp_c), 32'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]    rr_order [8];
        logic [WC-1:0] prod_tab [4];
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        prod_tab = '{18'h0001E, 18'h3FFC1, 18'h3FED4, 18'h10000};

        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
`ifdef MULT_SHARE_STATS_EN
        stat_clear = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_mul_valid", 32'(mul_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        setOperand(0, 10'd5,   8'd6);
        setOperand(1, 10'h3F9, 8'h09);
        setOperand(2, 10'd100, 8'hFD);
        setOperand(3, 10'h200, 8'h80);

        // All requesters valid: strict rotation 0..3 twice, back-to-back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'hF, 1'b1);
            checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_order[i]));
            checkOutput("rr_mul_valid", 32'(mul_valid), 32'd1);
            expq.push_back('{rr_order[i], prod_tab[rr_order[i]]});
        end

        applyStimulus(4'h0, 1'b1);
        setOperand(2, 10'h3FD, 8'h07);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_grant", 32'(req_ready), 32'h4);
        checkOutput("single_mul_a", 32'(mul_a), 32'h3FD);
        checkOutput("single_mul_b", 32'(mul_b), 32'h07);
        expq.push_back('{2'd2, 18'h3FFEB});

        applyStimulus(4'h0, 1'b1);
        checkOutput("idle_mul_valid", 32'(mul_valid), 32'd0);
        setOperand(3, 10'h1FF, 8'h7F);
        applyStimulus(4'b1000, 1'b1);
        checkOutput("max_grant", 32'(req_ready), 32'h8);
        expq.push_back('{2'd3, 18'h0FD81});

        // Backpressure: after wrap the pointer is 0, so requester 0 goes first.
        applyStimulus(4'h0, 1'b1);
        setOperand(3, 10'h200, 8'h80);
        applyStimulus(4'hF, 1'b1);
        checkOutput("wrap_grant", 32'(req_ready), 32'h1);
        expq.push_back('{2'd0, 18'h0001E});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'hF, 1'b0);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_mul_valid", 32'(mul_valid), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("bp_rsp_c", 32'(rsp_c), 32'h1E);
        end
        applyStimulus(4'hF, 1'b1);
        checkOutput("bp_release_grant", 32'(req_ready), 32'h2);
        expq.push_back('{2'd1, 18'h3FFC1});
        applyStimulus(4'h0, 1'b1);

        // Reset while a response is pending; that response is never consumed.
        applyStimulus(4'b0010, 1'b0);
        checkOutput("pre_reset_grant", 32'(req_ready), 32'h2);
        applyStimulus(4'h0, 1'b0);
        checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("async_reset_rsp_c", 32'(rsp_c), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(4'b1000, 1'b1);
        checkOutput("post_reset_grant", 32'(req_ready), 32'h8);
        expq.push_back('{2'd3, 18'h10000});
        applyStimulus(4'hF, 1'b1);
        checkOutput("post_reset_wrap", 32'(req_ready), 32'h1);
        expq.push_back('{2'd0, 18'h0001E});
        applyStimulus(4'h0, 1'b1);

`ifdef MULT_SHARE_STATS_EN
        @(posedge clk);
        #1 stat_clear = 1'b1;
        @(posedge clk);
        #1 stat_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0001, 1'b1);
            expq.push_back('{2'd0, 18'h0001E});
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b0);
        end
        applyStimulus(4'h0, 1'b1);
        checkOutput("stat_issue", stat_issue_cnt, 32'd5);
        checkOutput("stat_stall", stat_stall_cnt, 32'd3);
        stat_clear = 1'b1;
        applyStimulus(4'h0, 1'b1);
        stat_clear = 1'b0;
        checkOutput("stat_issue_clr", stat_issue_cnt, 32'd0);
        checkOutput("stat_stall_clr", stat_stall_cnt, 32'd0);
`endif

        for (int i = 0; i < 20 && expq.size() != 0; i++) begin
            @(posedge clk);
        end
        checkOutput("drain", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
